// File: rtl/counter_dco.sv
// counter_dco: digitally controlled oscillator built from a period counter.
// Ports: gen_clk_i/reset_i clock and async reset, enable_i run enable,
//   dco_cc_i signed fractional control code (positive = shorter period),
//   dco_clk_o oscillator output, period_start_o first-cycle pulse,
//   period_o integer length of the current period, clamp_o code saturated.
module counter_dco #(
    parameter int DCO_CC_WIDTH  = 8,
    parameter int FRAC_BITS     = 2,
    parameter int COUNT_WIDTH   = 8,
    parameter int CENTRE_PERIOD = 32,
    parameter int MIN_PERIOD    = 4,
    parameter int MAX_PERIOD    = 60
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
    output logic                           dco_clk_o,
    output logic                           period_start_o,
    output logic        [COUNT_WIDTH-1:0]  period_o,
    output logic                           clamp_o
);

    // Fixed-point width: wide enough that centre - code never overflows.
    localparam int FXA = COUNT_WIDTH + FRAC_BITS + 2;
    localparam int FXB = DCO_CC_WIDTH + 2;
    localparam int FXW = (FXA > FXB) ? FXA : FXB;

    localparam logic signed [FXW-1:0] CENTRE_FX =
        FXW'(CENTRE_PERIOD) << FRAC_BITS;
    localparam logic signed [FXW-1:0] MIN_FX =
        FXW'(MIN_PERIOD) << FRAC_BITS;
    localparam logic signed [FXW-1:0] MAX_FX =
        FXW'(MAX_PERIOD) << FRAC_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt;

    logic [COUNT_WIDTH-1:0] cnt_r;
    logic [COUNT_WIDTH-1:0] cnt_nxt;
    logic [COUNT_WIDTH-1:0] cnt_dec;
    logic [COUNT_WIDTH-1:0] period_nxt;
    logic [COUNT_WIDTH-1:0] int_part;
    logic [COUNT_WIDTH-1:0] period_p;
    logic                   clk_nxt;
    logic                   start_nxt;
    logic                   clamp_nxt;
    logic                   load;
    logic                   run_dec;

    logic signed [FXW-1:0] cc_fx;
    logic signed [FXW-1:0] raw_fx;
    logic signed [FXW-1:0] sat_fx;
    logic                  clamp_lo;
    logic                  clamp_hi;
    logic                  unused_fx;

    // Period arithmetic: clamp in fixed point, then split integer/fraction.
    assign cc_fx = {{(FXW-DCO_CC_WIDTH){dco_cc_i[DCO_CC_WIDTH-1]}}, dco_cc_i};
    assign raw_fx   = CENTRE_FX - cc_fx;
    assign clamp_lo = raw_fx < MIN_FX;
    assign clamp_hi = raw_fx > MAX_FX;
    assign sat_fx   = clamp_lo ? MIN_FX : (clamp_hi ? MAX_FX : raw_fx);
    assign int_part = sat_fx[COUNT_WIDTH+FRAC_BITS-1:FRAC_BITS];
    assign unused_fx = ^sat_fx[FXW-1:COUNT_WIDTH+FRAC_BITS];

    assign load    = enable_i && ((state_r == IDLE) || (cnt_r == '0));
    assign run_dec = (state_r == RUN) && (cnt_r != '0);
    assign cnt_dec = cnt_r - 1'b1;

    // Fractional accumulator: its carry stretches a period by one cycle,
    // so the average period tracks the fractional code.
    generate
        if (FRAC_BITS > 0) begin : g_acc
            logic [FRAC_BITS-1:0] acc_r;
            logic [FRAC_BITS-1:0] frac;
            logic [FRAC_BITS:0]   acc_sum;

            assign frac     = sat_fx[FRAC_BITS-1:0];
            assign acc_sum  = {1'b0, acc_r} + {1'b0, frac};
            assign period_p = int_part + COUNT_WIDTH'(acc_sum[FRAC_BITS]);

            always_ff @(posedge gen_clk_i or posedge reset_i) begin
                if (reset_i) begin
                    acc_r <= '0;
                end else if (load) begin
                    acc_r <= acc_sum[FRAC_BITS-1:0];
                end
            end
        end else begin : g_no_acc
            assign period_p = int_part;
        end
    endgenerate

    // State register
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic: a period is never cut short by enable_i.
    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            IDLE: if (enable_i) state_nxt = RUN;
            RUN:  if ((cnt_r == '0) && !enable_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / counter next values
    always_comb begin
        cnt_nxt    = cnt_r;
        clk_nxt    = 1'b0;
        start_nxt  = 1'b0;
        period_nxt = period_o;
        clamp_nxt  = clamp_o;
        unique case (1'b1)
            load: begin
                cnt_nxt    = period_p - 1'b1;
                clk_nxt    = 1'b1;
                start_nxt  = 1'b1;
                period_nxt = period_p;
                clamp_nxt  = clamp_lo | clamp_hi;
            end
            run_dec: begin
                cnt_nxt = cnt_dec;
                // High while remaining count covers the upper ceil(P/2).
                clk_nxt = cnt_dec >= (period_o >> 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r          <= '0;
            dco_clk_o      <= 1'b0;
            period_start_o <= 1'b0;
            period_o       <= '0;
            clamp_o        <= 1'b0;
        end else begin
            cnt_r          <= cnt_nxt;
            dco_clk_o      <= clk_nxt;
            period_start_o <= start_nxt;
            period_o       <= period_nxt;
            clamp_o        <= clamp_nxt;
        end
    end

endmodule

// File: tb/tb_counter_dco.sv
// tb_counter_dco: directed self-checking bench for counter_dco.
// Measures period length and high time between period_start_o pulses.
module tb_counter_dco;

    logic              gen_clk_i;
    logic              reset_i;
    logic              enable_i;
    logic signed [7:0] dco_cc_i;
    logic              dco_clk_o;
    logic              period_start_o;
    logic [7:0]        period_o;
    logic              clamp_o;

    int checks;
    int failures;

    counter_dco dut (
        .gen_clk_i      (gen_clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .dco_cc_i       (dco_cc_i),
        .dco_clk_o      (dco_clk_o),
        .period_start_o (period_start_o),
        .period_o       (period_o),
        .clamp_o        (clamp_o)
    );

    initial gen_clk_i = 1'b0;
    always #5 gen_clk_i = ~gen_clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Call at a negedge where period_start_o is high; returns at the
    // negedge of the next period_start_o.
    task automatic measure(input string tag, input int exp_len,
                           input int exp_hi);
        int len;
        int hi;
        len = 0;
        hi  = 0;
        do begin
            if (dco_clk_o) hi++;
            len++;
            @(negedge gen_clk_i);
        end while (!period_start_o && len < 200);
        check({tag, "_len"}, len, exp_len);
        check({tag, "_hi"}, hi, exp_hi);
    endtask

    initial begin
        int hi;
        int starts;
        checks   = 0;
        failures = 0;
        reset_i  = 1'b1;
        enable_i = 1'b0;
        dco_cc_i = 8'sd0;

        repeat (3) @(negedge gen_clk_i);
        check("rst_clk", int'(dco_clk_o), 0);
        check("rst_start", int'(period_start_o), 0);
        check("rst_period", int'(period_o), 0);
        check("rst_clamp", int'(clamp_o), 0);

        reset_i = 1'b0;
        @(negedge gen_clk_i);
        check("idle_clk", int'(dco_clk_o), 0);
        check("idle_start", int'(period_start_o), 0);

        enable_i = 1'b1;
        @(negedge gen_clk_i);
        check("lat_start", int'(period_start_o), 1);
        check("lat_clk", int'(dco_clk_o), 1);
        check("c0_period", int'(period_o), 32);
        check("c0_clamp", int'(clamp_o), 0);
        measure("c0_a", 32, 16);
        measure("c0_b", 32, 16);

        // Code change mid-period applies only from the next start.
        dco_cc_i = 8'sd8;
        measure("p8_mid", 32, 16);
        check("p8_period", int'(period_o), 30);
        dco_cc_i = -8'sd8;
        measure("p8", 30, 15);
        check("m8_period", int'(period_o), 34);
        dco_cc_i = 8'sd2;
        measure("m8", 34, 17);

        // Fractional dither: 31,32,31,32
        measure("fr_1", 31, 16);
        measure("fr_2", 32, 16);
        measure("fr_3", 31, 16);
        measure("fr_4", 32, 16);
        check("fr5_period", int'(period_o), 31);
        dco_cc_i = 8'sd127;
        measure("fr_5", 31, 16);

        check("sat_lo_period", int'(period_o), 4);
        check("sat_lo_clamp", int'(clamp_o), 1);
        dco_cc_i = -8'sd128;
        measure("sat_lo", 4, 2);
        check("sat_hi_period", int'(period_o), 60);
        check("sat_hi_clamp", int'(clamp_o), 1);
        dco_cc_i = 8'sd112;
        measure("sat_hi", 60, 30);
        check("edge_period", int'(period_o), 4);
        check("edge_clamp", int'(clamp_o), 0);
        dco_cc_i = 8'sd0;
        measure("edge", 4, 2);
        check("k_period", int'(period_o), 32);

        // Drop enable in cycle 5: period completes, then idle.
        hi     = 0;
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) enable_i = 1'b0;
            if (dco_clk_o) hi++;
            if (i > 0 && period_start_o) starts++;
            @(negedge gen_clk_i);
        end
        check("stop_hi", hi, 16);
        check("stop_starts", starts, 0);
        check("stop_clk", int'(dco_clk_o), 0);
        check("stop_period", int'(period_o), 32);

        enable_i = 1'b1;
        @(negedge gen_clk_i);
        check("restart_start", int'(period_start_o), 1);
        check("restart_clk", int'(dco_clk_o), 1);

        // Async reset between edges in the high phase.
        repeat (3) @(negedge gen_clk_i);
        #2 reset_i = 1'b1;
        #1;
        check("arst_clk", int'(dco_clk_o), 0);
        check("arst_start", int'(period_start_o), 0);
        check("arst_period", int'(period_o), 0);
        check("arst_clamp", int'(clamp_o), 0);
        dco_cc_i = 8'sd2;
        @(negedge gen_clk_i);
        reset_i = 1'b0;
        @(negedge gen_clk_i);
        check("fresh_start", int'(period_start_o), 1);
        check("fresh_period", int'(period_o), 31);
        measure("fresh", 31, 16);
        check("fresh_next", int'(period_o), 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
